// File: rtl/arb_mux2to1_pkg.sv
// Shared constants for the two-source arbitrated merge.
//   SRC0 / SRC1 : source identifiers carried alongside data (out_src encoding)
//   FifoDepth   : number of entries in the output FIFO
//   CntW        : width of the FIFO occupancy counter (holds 0..FifoDepth)
//   FifoFull    : occupancy value meaning "no free slot"
package arb_mux2to1_pkg;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

  localparam int unsigned FifoDepth = 2;
  localparam int unsigned CntW      = $clog2(FifoDepth + 1);

  localparam logic [CntW-1:0] FifoFull = CntW'(FifoDepth);

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter, purely combinational.
//   req[1:0]   : request from source 1 (bit 1) and source 0 (bit 0)
//   last_grant : source granted by the most recent accepted transfer
//   grant[1:0] : one-hot grant, or zero when nothing is requested
// A lone requester always wins; on contention the source that did not win
// last time is granted.
module rr_arbiter2
  import arb_mux2to1_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == SRC0) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/arb_mux2to1.sv
// Round-robin merge of two valid/ready sources into one output stream
// through a 2-entry FIFO of {data, src}.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   in0_valid/in0_data/in0_ready    : source-0 handshake
//   in1_valid/in1_data/in1_ready    : source-1 handshake
//   out_valid/out_data/out_src      : FIFO head (out_src: 0 = source 0, 1 = source 1)
//   out_ready                       : output consumer ready
// out_data/out_src come from dedicated registers so they hold their last
// value while the FIFO is empty and have no combinational path from inputs.
module arb_mux2to1
  import arb_mux2to1_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in0_valid,
  input  logic [N-1:0] in0_data,
  output logic         in0_ready,
  input  logic         in1_valid,
  input  logic [N-1:0] in1_data,
  output logic         in1_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  output logic         out_src,
  input  logic         out_ready
);

  logic [CntW-1:0] count_q, count_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic [N-1:0]    mem_data_q [FifoDepth];
  logic [N-1:0]    mem_data_d [FifoDepth];
  logic            mem_src_q  [FifoDepth];
  logic            mem_src_d  [FifoDepth];
  logic [N-1:0]    out_data_q, out_data_d;
  logic            out_src_q, out_src_d;
  logic            last_grant_q, last_grant_d;

  logic [1:0]   grant;
  logic         can_push;
  logic         push;
  logic         pop;
  logic         push_src;
  logic [N-1:0] push_data;

  rr_arbiter2 u_arb (
    .req        ({in1_valid, in0_valid}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // A full FIFO can still take a push when the head leaves in the same cycle.
  // rst_n gates readiness so nothing is offered while reset is held.
  assign can_push  = rst_n & ((count_q != FifoFull) | out_ready);
  assign in0_ready = grant[0] & can_push;
  assign in1_ready = grant[1] & can_push;

  assign push      = (in0_valid & in0_ready) | (in1_valid & in1_ready);
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;

  assign push_src  = grant[1] ? SRC1 : SRC0;
  assign push_data = grant[1] ? in1_data : in0_data;

  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

  always_comb begin
    mem_data_d   = mem_data_q;
    mem_src_d    = mem_src_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;

    if (push) begin
      // When full with a pop, wr_ptr == rd_ptr: the slot being vacated is reused.
      mem_data_d[wr_ptr_q] = push_data;
      mem_src_d[wr_ptr_q]  = push_src;
      wr_ptr_d             = ~wr_ptr_q;
      last_grant_d         = push_src;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Preload the next head so it is visible in the cycle after acceptance.
    if (count_d != '0) begin
      out_data_d = mem_data_d[rd_ptr_d];
      out_src_d  = mem_src_d[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= SRC0;
      last_grant_q <= SRC1;
      for (int i = 0; i < FifoDepth; i++) begin
        mem_data_q[i] <= '0;
        mem_src_q[i]  <= SRC0;
      end
    end else begin
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      last_grant_q <= last_grant_d;
      mem_data_q   <= mem_data_d;
      mem_src_q    <= mem_src_d;
    end
  end

endmodule

// File: tb/tb_arb_mux2to1.sv
module tb_arb_mux2to1;

  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in0_valid, in1_valid;
  logic [N-1:0] in0_data, in1_data;
  logic         in0_ready, in1_ready;
  logic         out_valid;
  logic [N-1:0] out_data;
  logic         out_src;
  logic         out_ready;

  int tests = 0;
  int fails = 0;

  // Scoreboard entries are {src, data} in acceptance order.
  logic [N:0] sb_q [$];
  logic [N:0] sb_exp;

  always #5 clk = ~clk;

  arb_mux2to1 #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Handshakes seen mid-cycle complete at the following rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_exclusive", {63'd0, in0_ready & in1_ready}, 64'd0);
      if (out_valid && out_ready) begin
        chk("sb_expect_avail", {63'd0, sb_q.size() != 0}, 64'd1);
        if (sb_q.size() != 0) begin
          sb_exp = sb_q.pop_front();
          chk("sb_data", {32'd0, out_data}, {32'd0, sb_exp[N-1:0]});
          chk("sb_src", {63'd0, out_src}, {63'd0, sb_exp[N]});
        end
      end
      if (in0_valid && in0_ready) sb_q.push_back({1'b0, in0_data});
      if (in1_valid && in1_ready) sb_q.push_back({1'b1, in1_data});
    end
  end

  initial begin
    rst_n     = 1'b0;
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    in0_data  = 32'h11;
    in1_data  = 32'h22;
    out_ready = 1'b1;

    // Reset held with both sources requesting.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in0_ready", in0_ready, 0);
      chk("rst_in1_ready", in1_ready, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_src", out_src, 0);
    end

    // Contention straight out of reset: source 0 first, then alternate.
    next_cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("cont_in0_ready", in0_ready, (k % 2) == 0);
      chk("cont_in1_ready", in1_ready, (k % 2) == 1);
      if (k > 0) begin
        chk("cont_out_valid", out_valid, 1);
        chk("cont_src", out_src, (k - 1) % 2);
        chk("cont_data", out_data, ((k - 1) % 2 == 1) ? 32'h22 : 32'h11);
      end
      next_cycle();
    end
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    @(negedge clk);
    chk("cont_last_src", out_src, 1);
    chk("cont_last_data", out_data, 32'h22);
    next_cycle();
    @(negedge clk);
    chk("empty_out_valid", out_valid, 0);
    chk("empty_hold_data", out_data, 32'h22);
    chk("empty_hold_src", out_src, 1);

    // Single source, one-cycle latency.
    next_cycle();
    in0_valid = 1'b1;
    in0_data  = 32'hA5A5A5A5;
    @(negedge clk);
    chk("single_in0_ready", in0_ready, 1);
    next_cycle();
    in0_valid = 1'b0;
    @(negedge clk);
    chk("single_out_valid", out_valid, 1);
    chk("single_out_data", out_data, 32'hA5A5A5A5);
    chk("single_out_src", out_src, 0);

    // Backpressure: in1 sends 1,2,3 with out_ready low.
    next_cycle();
    out_ready = 1'b0;
    in1_valid = 1'b1;
    in1_data  = 32'h1;
    @(negedge clk);
    chk("bp_ready_1", in1_ready, 1);
    next_cycle();
    in1_data = 32'h2;
    @(negedge clk);
    chk("bp_ready_2", in1_ready, 1);
    chk("bp_head_1", out_data, 32'h1);
    next_cycle();
    in1_data = 32'h3;
    @(negedge clk);
    chk("bp_full_ready", in1_ready, 0);
    chk("bp_head_stable", out_data, 32'h1);
    chk("bp_head_src", out_src, 1);
    next_cycle();
    @(negedge clk);
    chk("bp_full_ready_b", in1_ready, 0);
    chk("bp_head_stable_b", out_data, 32'h1);
    next_cycle();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_full_pop_ready", in1_ready, 1);
    next_cycle();
    in1_valid = 1'b0;
    @(negedge clk);
    chk("bp_out_2", out_data, 32'h2);
    next_cycle();
    @(negedge clk);
    chk("bp_out_3", out_data, 32'h3);
    next_cycle();
    @(negedge clk);
    chk("bp_drained", out_valid, 0);

    // Full FIFO with simultaneous pop and push.
    next_cycle();
    out_ready = 1'b0;
    in1_valid = 1'b1;
    in1_data  = 32'h4;
    next_cycle();
    in1_data = 32'h5;
    next_cycle();
    in1_valid = 1'b0;
    in0_valid = 1'b1;
    in0_data  = 32'h7;
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_in0_ready", in0_ready, 1);
    chk("full_head_4", out_data, 32'h4);
    next_cycle();
    in0_valid = 1'b0;
    out_ready = 1'b0;
    in1_valid = 1'b1;
    in1_data  = 32'hEE;
    @(negedge clk);
    chk("full_still_full", in1_ready, 0);
    chk("full_out_valid", out_valid, 1);
    chk("full_head_5", out_data, 32'h5);
    next_cycle();
    in1_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_out_5", out_data, 32'h5);
    next_cycle();
    @(negedge clk);
    chk("full_out_7", out_data, 32'h7);
    chk("full_out_7_src", out_src, 0);
    next_cycle();
    @(negedge clk);
    chk("full_drained", out_valid, 0);

    // Mid-operation reset with two entries queued.
    next_cycle();
    out_ready = 1'b0;
    in1_valid = 1'b1;
    in1_data  = 32'h8;
    next_cycle();
    in1_data = 32'h9;
    next_cycle();
    in1_valid = 1'b0;
    @(negedge clk);
    chk("mid_pre_full", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_async_valid", out_valid, 0);
    chk("mid_async_data", out_data, 0);
    sb_q.delete();
    in0_valid = 1'b1;
    in0_data  = 32'hC;
    in1_valid = 1'b1;
    in1_data  = 32'hD;
    out_ready = 1'b1;
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_in0_ready", in0_ready, 1);
    chk("mid_in1_ready", in1_ready, 0);
    next_cycle();
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    @(negedge clk);
    chk("mid_out_valid", out_valid, 1);
    chk("mid_out_src", out_src, 0);
    chk("mid_out_data", out_data, 32'hC);
    next_cycle();
    @(negedge clk);
    chk("mid_drained", out_valid, 0);
    chk("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/arb_mux2to1.md
ARB_MUX2TO1 -- requirements
Module: arb_mux2to1

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the data width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have ports in0_valid (input, 1), in0_data (input, N) and in0_ready (output, 1): the source-0 handshake.
REQ-005 The block SHALL have ports in1_valid (input, 1), in1_data (input, N) and in1_ready (output, 1): the source-1 handshake.
REQ-006 The block SHALL have ports out_valid (output, 1), out_data (output, N), out_src (output, 1; 0 = source 0, 1 = source 1) and out_ready (input, 1): the merged output handshake.

Function
REQ-007 A transfer SHALL occur on a channel in any cycle where its valid and ready are both 1 at the rising clk edge.
REQ-008 The block SHALL contain a 2-entry FIFO holding {data, src}, with count 0..2, and SHALL preserve acceptance order on the output.
REQ-009 The block SHALL accept at most one input transfer per cycle.
REQ-010 The arbiter SHALL grant the only valid source when exactly one of in0_valid and in1_valid is 1.
REQ-011 When both sources are valid, the arbiter SHALL grant the source not granted by the most recent accepted transfer (round-robin).
REQ-012 The last_grant register SHALL update only on an accepted input transfer; it SHALL NOT update on a grant that is not accepted.
REQ-013 inX_ready SHALL be 1 only for the granted source, and only when count<2, or when count==2 and out_ready==1 (simultaneous pop frees a slot).
REQ-014 The ungranted source's ready SHALL be 0.
REQ-015 inX_ready SHALL NOT depend on that same source's inX_data.
REQ-016 out_valid SHALL equal (count!=0); out_data and out_src SHALL present the FIFO head, registered with no combinational path from inputs.
REQ-017 Latency: data accepted at edge k with the FIFO empty SHALL appear on out_* at the output from edge k onward, i.e. be visible in cycle k+1.
REQ-018 On a simultaneous push and pop, count SHALL remain unchanged and the FIFO head SHALL advance.
REQ-019 When out_valid is 1 and out_ready is 0, out_data and out_src SHALL hold stable.
REQ-020 When count==0, out_data and out_src SHALL keep their last values; only out_valid is meaningful.
REQ-021 When both sources stay valid and out_ready stays 1, the accepted sources SHALL alternate 0,1,0,1 with one acceptance per cycle.

Reset
REQ-022 While rst_n==0, the block SHALL hold count=0, out_valid=0, out_data=0, out_src=0, FIFO pointers=0 and last_grant=1, so that source 0 wins the first contention.
REQ-023 Assertion of rst_n mid-operation SHALL immediately discard all queued entries, with no output transfer completing in that cycle.
REQ-024 After deassertion of rst_n, the block SHALL accept input on the first rising edge.

Structure
REQ-025 Constants SRC0=1'b0 and SRC1=1'b1 and the FIFO depth (2) SHALL live in the shared common package.
REQ-026 Round-robin grant logic SHALL be one sub-module, rr_arbiter2 (inputs req[1:0] and last_grant; output grant[1:0], one-hot or zero).
REQ-027 The FIFO SHALL be coded inline in arb_mux2to1.

Verification
REQ-028 Reset: hold rst_n=0, drive in0_valid=1 and in1_valid=1 -> out_valid=0, in0_ready=0, in1_ready=0 and out_data=0 throughout.
REQ-029 Single source: in0 sends 0xA5A5A5A5 with out_ready=1 -> next cycle out_valid=1, out_data=0xA5A5A5A5, out_src=0.
REQ-030 Contention: both sources valid continuously (in0=0x11, in1=0x22) with out_ready=1 -> out_src sequence 0,1,0,1 and data 0x11,0x22,0x11,0x22.
REQ-031 Backpressure: out_ready=0 while in1 sends 0x1, 0x2, 0x3 -> the first two are accepted, then in1_ready=0; raising out_ready yields 0x1, 0x2, 0x3 in order with no loss or duplication.
REQ-032 Full with simultaneous pop: count=2, out_ready=1, in0 valid with 0x7 -> in0_ready=1, count stays 2, and 0x7 is emitted third.
REQ-033 Mid-operation reset: pulse rst_n=0 with count=2 -> out_valid drops to 0 asynchronously, and the first output after release is newly accepted data from source 0.
